// File: rtl/alu_pkg.sv
// alu_pkg: opcodes and FSM state encoding shared by the
// handshake ALU slice.
package alu_pkg;

  localparam logic [3:0] OP_ADDU = 4'h0;
  localparam logic [3:0] OP_ADDS = 4'h1;
  localparam logic [3:0] OP_SUBU = 4'h2;
  localparam logic [3:0] OP_SUBS = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_SHR1 = 4'h7;
  localparam logic [3:0] OP_SLL  = 4'h8;
  localparam logic [3:0] OP_SRL  = 4'h9;
  localparam logic [3:0] OP_SRA  = 4'hA;
  localparam logic [3:0] OP_MULU = 4'hB;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/handshake_alu_if.sv
// handshake_alu_if: operand issue and result retire
// handshakes of the ALU bundled as one port.
interface handshake_alu_if #(
  parameter int NUMBITS = 8
);

  logic               in_valid;
  logic               in_ready;
  logic [NUMBITS-1:0] A;
  logic [NUMBITS-1:0] B;
  logic [3:0]         opcode;
  logic               out_valid;
  logic               out_ready;
  logic [NUMBITS-1:0] result;
  logic               carryout;
  logic               overflow;
  logic               zero;
  logic               err;

  modport master (
    output in_valid, A, B, opcode, out_ready,
    input  in_ready, out_valid, result,
    input  carryout, overflow, zero, err
  );

  modport slave (
    input  in_valid, A, B, opcode, out_ready,
    output in_ready, out_valid, result,
    output carryout, overflow, zero, err
  );

endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add unsigned multiplier,
// one partial product per clock, NUMBITS clocks per op.
module alu_mul_seq #(
  parameter int NUMBITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUMBITS-1:0]   a,
  input  logic [NUMBITS-1:0]   b,
  output logic                 done,
  output logic [2*NUMBITS-1:0] product
);

  localparam int CW = $clog2(NUMBITS);
  localparam logic [CW-1:0] LAST = CW'(NUMBITS - 1);

  logic                 busy;
  logic [CW-1:0]        cnt;
  logic [2*NUMBITS-1:0] acc;
  logic [2*NUMBITS-1:0] mcand;
  logic [NUMBITS-1:0]   mplier;
  logic [2*NUMBITS-1:0] addend;

  // product is combinational so the final iteration's
  // sum is visible on the edge that completes the op
  assign addend  = mplier[0] ? mcand : '0;
  assign product = acc + addend;
  assign done    = busy & (cnt == LAST);

  // load operands on start, then accumulate and shift
  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= {{NUMBITS{1'b0}}, a};
      mplier <= b;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (done) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/handshake_alu.sv
// handshake_alu: NUMBITS-wide ALU with valid/ready on both
// sides. Define ALU_MUL_EN to build the multi-cycle MULU.
module handshake_alu
  import alu_pkg::*;
#(
  parameter int NUMBITS = 8
) (
  input logic            clk,
  input logic            reset,
  handshake_alu_if.slave bus
);

  localparam int SHW = $clog2(NUMBITS);

  state_t state_q;
  state_t state_d;

  logic               accept;
  logic               is_mul;
  logic               mul_done;
  logic               fin_alu;
  logic               fin_mul;
  logic [NUMBITS:0]   sum;
  logic [NUMBITS:0]   dif;
  logic [SHW-1:0]     sh;
  logic [NUMBITS-1:0] alu_r;
  logic               alu_co;
  logic               alu_ov;
  logic               alu_err;

  assign bus.in_ready  = (state_q == ST_IDLE) |
                         ((state_q == ST_DONE) & bus.out_ready);
  assign bus.out_valid = (state_q == ST_DONE);
  assign accept        = bus.in_valid & bus.in_ready;

`ifdef ALU_MUL_EN
  logic [2*NUMBITS-1:0] prod;

  assign is_mul = (bus.opcode == OP_MULU);

  alu_mul_seq #(
    .NUMBITS(NUMBITS)
  ) u_mul (
    .clk    (clk),
    .reset  (reset),
    .start  (accept & is_mul),
    .a      (bus.A),
    .b      (bus.B),
    .done   (mul_done),
    .product(prod)
  );
`else
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
`endif

  assign fin_alu = accept & ~is_mul;
  assign fin_mul = (state_q == ST_EXEC) & mul_done;

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // next state: accepts go to DONE or EXEC by opcode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = is_mul ? ST_EXEC : ST_DONE;
      end
      ST_EXEC: begin
        if (mul_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (accept)             state_d = is_mul ? ST_EXEC : ST_DONE;
        else if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // single-cycle datapath; MULU falls to default here and
  // is never used from this path
  always_comb begin
    sum     = {1'b0, bus.A} + {1'b0, bus.B};
    dif     = {1'b0, bus.A} - {1'b0, bus.B};
    sh      = bus.B[SHW-1:0];
    alu_r   = '0;
    alu_co  = 1'b0;
    alu_ov  = 1'b0;
    alu_err = 1'b0;
    unique case (bus.opcode)
      OP_ADDU: begin
        alu_r  = sum[NUMBITS-1:0];
        alu_co = sum[NUMBITS];
        alu_ov = sum[NUMBITS];
      end
      OP_ADDS: begin
        alu_r  = sum[NUMBITS-1:0];
        alu_ov = (bus.A[NUMBITS-1] == bus.B[NUMBITS-1]) &
                 (sum[NUMBITS-1] != bus.A[NUMBITS-1]);
      end
      OP_SUBU: begin
        alu_r  = dif[NUMBITS-1:0];
        alu_co = dif[NUMBITS];
        alu_ov = dif[NUMBITS];
      end
      OP_SUBS: begin
        alu_r  = dif[NUMBITS-1:0];
        alu_ov = (bus.A[NUMBITS-1] != bus.B[NUMBITS-1]) &
                 (dif[NUMBITS-1] != bus.A[NUMBITS-1]);
      end
      OP_AND:  alu_r = bus.A & bus.B;
      OP_OR:   alu_r = bus.A | bus.B;
      OP_XOR:  alu_r = bus.A ^ bus.B;
      OP_SHR1: alu_r = {1'b0, bus.A[NUMBITS-1:1]};
      OP_SLL:  alu_r = bus.A << sh;
      OP_SRL:  alu_r = bus.A >> sh;
      OP_SRA:  alu_r = NUMBITS'($signed(bus.A) >>> sh);
      default: alu_err = 1'b1;
    endcase
  end

  // result and flags change only on the edge finishing an op
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.result   <= '0;
      bus.carryout <= 1'b0;
      bus.overflow <= 1'b0;
      bus.zero     <= 1'b0;
      bus.err      <= 1'b0;
    end else if (fin_alu) begin
      bus.result   <= alu_r;
      bus.carryout <= alu_co;
      bus.overflow <= alu_ov;
      bus.zero     <= (alu_r == '0);
      bus.err      <= alu_err;
`ifdef ALU_MUL_EN
    end else if (fin_mul) begin
      bus.result   <= prod[NUMBITS-1:0];
      bus.carryout <= |prod[2*NUMBITS-1:NUMBITS];
      bus.overflow <= |prod[2*NUMBITS-1:NUMBITS];
      bus.zero     <= (prod[NUMBITS-1:0] == '0);
      bus.err      <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_handshake_alu.sv
// tb_handshake_alu: directed vectors for handshake_alu at
// NUMBITS=8, with MULU cases when ALU_MUL_EN is defined.
module tb_handshake_alu;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  handshake_alu_if #(.NUMBITS(8)) bus ();

  handshake_alu #(
    .NUMBITS(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] obs();
    return {bus.out_valid, bus.result, bus.carryout,
            bus.overflow, bus.zero, bus.err};
  endfunction

  task automatic drive(input logic [3:0] op,
                       input logic [7:0] a,
                       input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.A        = a;
    bus.B        = b;
  endtask

  // issue one op from idle, check it, then retire it
  task automatic single(input string tag,
                        input logic [3:0] op,
                        input logic [7:0] a,
                        input logic [7:0] b,
                        input logic [7:0] r,
                        input logic co, input logic ov,
                        input logic z, input logic e);
    drive(op, a, b);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk(tag, 32'(obs()), 32'({1'b1, r, co, ov, z, e}));
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
  endtask

`ifdef ALU_MUL_EN
  task automatic mul(input string tag,
                     input logic [7:0] a,
                     input logic [7:0] b,
                     input logic [7:0] r,
                     input logic co, input logic z);
    int   n;
    logic rdy;
    rdy = 1'b0;
    drive(4'hB, a, b);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    n = 1;
    @(negedge clk);
    while (!bus.out_valid && n < 20) begin
      if (bus.in_ready) rdy = 1'b1;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({tag, "_lat"}, 32'(n), 32'd9);
    chk({tag, "_rdy"}, 32'(rdy), 32'd0);
    chk(tag, 32'(obs()), 32'({1'b1, r, co, co, z, 1'b0}));
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
  endtask
`endif

  logic [7:0] xa [4];
  logic [7:0] xb [4];
  logic [7:0] xr [4];

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.opcode    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out", 32'(obs()), 32'd0);
    chk("rst_rdy", 32'(bus.in_ready), 32'd1);
    reset = 1'b0;
    @(negedge clk);

    single("addu_wrap", 4'h0, 8'hFF, 8'h01, 8'h00, 1, 1, 1, 0);
    single("addu",      4'h0, 8'h12, 8'h34, 8'h46, 0, 0, 0, 0);
    single("adds_ov",   4'h1, 8'h7F, 8'h01, 8'h80, 0, 1, 0, 0);
    single("adds_neg",  4'h1, 8'h80, 8'hFF, 8'h7F, 0, 1, 0, 0);
    single("subu_brw",  4'h2, 8'h03, 8'h05, 8'hFE, 1, 1, 0, 0);
    single("subu_eq",   4'h2, 8'hFF, 8'hFF, 8'h00, 0, 0, 1, 0);
    single("subs_ov",   4'h3, 8'h80, 8'h01, 8'h7F, 0, 1, 0, 0);
    single("subs_ov2",  4'h3, 8'h7F, 8'hFF, 8'h80, 0, 1, 0, 0);
    single("and_z",     4'h4, 8'hFF, 8'h00, 8'h00, 0, 0, 1, 0);
    single("or",        4'h5, 8'h0F, 8'h30, 8'h3F, 0, 0, 0, 0);
    single("xor",       4'h6, 8'hA5, 8'hFF, 8'h5A, 0, 0, 0, 0);
    single("shr1",      4'h7, 8'h12, 8'hFF, 8'h09, 0, 0, 0, 0);
    single("sll",       4'h8, 8'h01, 8'h07, 8'h80, 0, 0, 0, 0);
    single("sll_hi_b",  4'h8, 8'hFF, 8'h0A, 8'hFC, 0, 0, 0, 0);
    single("srl_hi_b",  4'h9, 8'h80, 8'h0B, 8'h10, 0, 0, 0, 0);
    single("sra_neg",   4'hA, 8'h80, 8'h03, 8'hF0, 0, 0, 0, 0);
    single("sra_pos",   4'hA, 8'h40, 8'h02, 8'h10, 0, 0, 0, 0);
    single("ill_c",     4'hC, 8'hFF, 8'hFF, 8'h00, 0, 0, 1, 1);
    single("ill_f",     4'hF, 8'h12, 8'h34, 8'h00, 0, 0, 1, 1);
    single("sra_clr",   4'hA, 8'h7F, 8'h00, 8'h7F, 0, 0, 0, 0);

`ifdef ALU_MUL_EN
    mul("mul_ff",  8'h0F, 8'h11, 8'hFF, 0, 0);
    mul("mul_hi",  8'h10, 8'h10, 8'h00, 1, 1);
    mul("mul_mix", 8'h0D, 8'h0B, 8'h8F, 0, 0);

    drive(4'hB, 8'h0F, 8'h11);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_exec_rdy", 32'(bus.in_ready), 32'd1);
    begin
      logic seen;
      seen = 1'b0;
      repeat (12) begin
        @(negedge clk);
        if (bus.out_valid) seen = 1'b1;
      end
      chk("rst_exec_nov", 32'(seen), 32'd0);
    end
`else
    single("mul_ill", 4'hB, 8'h05, 8'h03, 8'h00, 0, 0, 1, 1);
`endif

    xa[0] = 8'h0F; xb[0] = 8'hF0; xr[0] = 8'hFF;
    xa[1] = 8'hAA; xb[1] = 8'h0F; xr[1] = 8'hA5;
    xa[2] = 8'h33; xb[2] = 8'h33; xr[2] = 8'h00;
    xa[3] = 8'h81; xb[3] = 8'h18; xr[3] = 8'h99;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(4'h6, xa[i], xb[i]);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("b2b_%0d", i),
          32'({bus.out_valid, bus.in_ready, bus.result}),
          32'({1'b1, 1'b1, xr[i]}));
    end

    bus.out_ready = 1'b0;
    drive(4'h6, 8'h01, 8'h02);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("stall_%0d", i),
          32'({bus.out_valid, bus.in_ready, bus.result}),
          32'({1'b1, 1'b0, 8'h99}));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("stall_next", 32'({bus.out_valid, bus.result}),
        32'({1'b1, 8'h03}));
    @(posedge clk);
    @(negedge clk);
    chk("drain_idle", 32'({bus.out_valid, bus.in_ready}),
        32'({1'b0, 1'b1}));
    bus.out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
